ysyx_24110017_axi_burst_mem: RTL and testbench



---
 rtl/ysyx_24110017_axi_burst_mem_if.sv | 52 +++++
 rtl/ysyx_24110017_axi_burst_mem.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ysyx_24110017_axi_burst_mem.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110017_axi_burst_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110017_axi_burst_mem_if
// Brief    : AXI4 bus bundle between the core master and the burst memory.
// Revision : 1.0
// ============================================================================
interface ysyx_24110017_axi_burst_mem_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24110017_axi_burst_mem.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110017_axi_burst_mem
// Brief    : AXI4 slave memory with FIXED/INCR bursts, programmable latency,
//            byte strobes and DECERR/SLVERR. YSYX_24110017_MEM_RAND_DELAY_EN
//            adds LFSR-driven extra latency and read bubbles.
// Revision : 1.0
// ============================================================================
module ysyx_24110017_axi_burst_mem #(
    parameter int          DATA_W    = 32,
    parameter int          ID_W      = 4,
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_BYTES = 65536,
    parameter int          RD_LAT    = 3,
    parameter int          WR_LAT    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_24110017_axi_burst_mem_if.slave  bus
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_SH  = $clog2(STRB_W);
    localparam int OFF_W    = $clog2(MEM_BYTES);
    localparam int WORDS    = MEM_BYTES / STRB_W;

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

    function automatic logic [1:0] resp_f(input logic dec, input logic slv);
        return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
    endfunction

    logic [2:0] rand_lat;
    logic       rand_bubble;
`ifdef YSYX_24110017_MEM_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
    assign rand_lat    = lfsr_q[2:0];
    assign rand_bubble = lfsr_q[3];
`else
    assign rand_lat    = 3'd0;
    assign rand_bubble = 1'b0;
`endif

    logic [15:0] wr_lat_new, rd_lat_new;
    assign wr_lat_new = 16'(WR_LAT) + {13'd0, rand_lat};
    assign rd_lat_new = 16'(RD_LAT) + {13'd0, rand_lat};

    logic [DATA_W-1:0] mem_q [WORDS];

    // ---------------- write channel ----------------
    logic [1:0]        wr_state_q, wr_state_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [31:0]       aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d, wr_cnt_q, wr_cnt_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic [15:0]       wr_lat_q, wr_lat_d;
    logic              wr_dec_q, wr_dec_d, wr_slv_q, wr_slv_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic [32:0] wr_off;
    logic        wr_in_rng, wr_hs, wr_we;
    assign wr_off    = {1'b0, aw_addr_q} - {1'b0, MEM_BASE};
    assign wr_in_rng = ({1'b0, aw_addr_q} >= {1'b0, MEM_BASE}) && (wr_off < 33'(MEM_BYTES));
    assign wr_hs     = bus.wvalid && wready_q;
    assign wr_we     = wr_hs && wr_in_rng && !reset;

    always_comb begin
        wr_state_d = wr_state_q;  aw_id_d = aw_id_q;      aw_addr_d = aw_addr_q;
        aw_len_d   = aw_len_q;    aw_size_d = aw_size_q;  aw_burst_d = aw_burst_q;
        wr_cnt_d   = wr_cnt_q;    wr_lat_d = wr_lat_q;    wr_dec_d = wr_dec_q;
        wr_slv_d   = wr_slv_q;    awready_d = awready_q;  wready_d = wready_q;
        bvalid_d   = bvalid_q;    bid_d = bid_q;          bresp_d = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (bus.awvalid && awready_q) begin
                    aw_id_d    = bus.awid;    aw_addr_d  = bus.awaddr;
                    aw_len_d   = bus.awlen;   aw_size_d  = bus.awsize;
                    aw_burst_d = bus.awburst; wr_lat_d   = wr_lat_new;
                    wr_cnt_d   = 8'd0;        wr_dec_d   = 1'b0;
                    wr_slv_d   = bus.awburst[1];
                    awready_d  = 1'b0;        wready_d   = 1'b1;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_hs) begin
                    if (!wr_in_rng) wr_dec_d = 1'b1;
                    if (aw_burst_q != BURST_FIXED) aw_addr_d = aw_addr_q + (32'd1 << aw_size_q);
                    wr_cnt_d = wr_cnt_q + 8'd1;
                    if ((wr_cnt_q == aw_len_q) || bus.wlast) begin
                        // wlast must coincide with beat awlen; any mismatch is a protocol error
                        if ((wr_cnt_q == aw_len_q) != bus.wlast) wr_slv_d = 1'b1;
                        wready_d = 1'b0;
                        if (wr_lat_q == 16'd0) begin
                            wr_state_d = W_RESP;
                            bvalid_d   = 1'b1;
                            bid_d      = aw_id_q;
                            bresp_d    = resp_f(wr_dec_d, wr_slv_d);
                        end else begin
                            wr_state_d = W_WAIT;
                            wr_lat_d   = wr_lat_q - 16'd1;
                        end
                    end
                end
            end
            W_WAIT: begin
                if (wr_lat_q == 16'd0) begin
                    wr_state_d = W_RESP;
                    bvalid_d   = 1'b1;
                    bid_d      = aw_id_q;
                    bresp_d    = resp_f(wr_dec_q, wr_slv_q);
                end else begin
                    wr_lat_d = wr_lat_q - 16'd1;
                end
            end
            default: begin
                if (bus.bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.wstrb[i]) mem_q[wr_off[OFF_W-1:BYTE_SH]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic [1:0]        rd_state_q, rd_state_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [31:0]       ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d, rd_cnt_q, rd_cnt_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [15:0]       rd_lat_q, rd_lat_d;
    logic              rd_slv_q, rd_slv_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_load, rd_in_rng;
    logic [32:0]       rd_off;

    always_comb begin
        rd_state_d = rd_state_q;  ar_id_d = ar_id_q;      ar_addr_d = ar_addr_q;
        ar_len_d   = ar_len_q;    ar_size_d = ar_size_q;  ar_burst_d = ar_burst_q;
        rd_cnt_d   = rd_cnt_q;    rd_lat_d = rd_lat_q;    rd_slv_d = rd_slv_q;
        arready_d  = arready_q;   rvalid_d = rvalid_q;    rlast_d = rlast_q;
        rid_d      = rid_q;       rdata_d = rdata_q;      rresp_d = rresp_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.arvalid && arready_q) begin
                    ar_id_d    = bus.arid;    ar_addr_d = bus.araddr;
                    ar_len_d   = bus.arlen;   ar_size_d = bus.arsize;
                    ar_burst_d = bus.arburst; rd_cnt_d  = 8'd0;
                    rd_slv_d   = bus.arburst[1];
                    arready_d  = 1'b0;
                    if (rd_lat_new == 16'd0) begin
                        rd_state_d = R_DATA;
                        rd_load    = 1'b1;
                    end else begin
                        rd_state_d = R_WAIT;
                        rd_lat_d   = rd_lat_new - 16'd1;
                    end
                end
            end
            R_WAIT: begin
                if (rd_lat_q == 16'd0) begin
                    rd_state_d = R_DATA;
                    rd_load    = 1'b1;
                end else begin
                    rd_lat_d = rd_lat_q - 16'd1;
                end
            end
            default: begin
                if (rvalid_q && bus.rready) begin
                    if (rd_cnt_q == ar_len_q) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 8'd1;
                        if (ar_burst_q != BURST_FIXED) ar_addr_d = ar_addr_q + (32'd1 << ar_size_q);
                        if (rand_bubble) rvalid_d = 1'b0;
                        else             rd_load  = 1'b1;
                    end
                end else if (!rvalid_q) begin
                    rd_load = 1'b1;
                end
            end
        endcase

        // Beat data is captured from the address the next beat will present
        rd_off    = {1'b0, ar_addr_d} - {1'b0, MEM_BASE};
        rd_in_rng = ({1'b0, ar_addr_d} >= {1'b0, MEM_BASE}) && (rd_off < 33'(MEM_BYTES));
        if (rd_load) begin
            rvalid_d = 1'b1;
            rid_d    = ar_id_d;
            rdata_d  = rd_in_rng ? mem_q[rd_off[OFF_W-1:BYTE_SH]] : '0;
            rresp_d  = rd_in_rng ? (rd_slv_d ? RESP_SLVERR : RESP_OKAY) : RESP_DECERR;
            rlast_d  = (rd_cnt_d == ar_len_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE; aw_id_q <= '0;   aw_addr_q <= '0;  aw_len_q <= '0;
            aw_size_q <= '0;      aw_burst_q <= '0; wr_cnt_q <= '0;  wr_lat_q <= '0;
            wr_dec_q <= 1'b0;     wr_slv_q <= 1'b0; awready_q <= 1'b0; wready_q <= 1'b0;
            bvalid_q <= 1'b0;     bid_q <= '0;      bresp_q <= '0;
            rd_state_q <= R_IDLE; ar_id_q <= '0;   ar_addr_q <= '0;  ar_len_q <= '0;
            ar_size_q <= '0;      ar_burst_q <= '0; rd_cnt_q <= '0;  rd_lat_q <= '0;
            rd_slv_q <= 1'b0;     arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rid_q <= '0;          rdata_q <= '0;    rresp_q <= '0;
        end else begin
            wr_state_q <= wr_state_d; aw_id_q <= aw_id_d;       aw_addr_q <= aw_addr_d;
            aw_len_q <= aw_len_d;     aw_size_q <= aw_size_d;   aw_burst_q <= aw_burst_d;
            wr_cnt_q <= wr_cnt_d;     wr_lat_q <= wr_lat_d;     wr_dec_q <= wr_dec_d;
            wr_slv_q <= wr_slv_d;     awready_q <= awready_d;   wready_q <= wready_d;
            bvalid_q <= bvalid_d;     bid_q <= bid_d;           bresp_q <= bresp_d;
            rd_state_q <= rd_state_d; ar_id_q <= ar_id_d;       ar_addr_q <= ar_addr_d;
            ar_len_q <= ar_len_d;     ar_size_q <= ar_size_d;   ar_burst_q <= ar_burst_d;
            rd_cnt_q <= rd_cnt_d;     rd_lat_q <= rd_lat_d;     rd_slv_q <= rd_slv_d;
            arready_q <= arready_d;   rvalid_q <= rvalid_d;     rlast_q <= rlast_d;
            rid_q <= rid_d;           rdata_q <= rdata_d;       rresp_q <= rresp_d;
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110017_axi_burst_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24110017_axi_burst_mem
// Brief    : Scoreboard bench for the AXI burst memory (default build).
// Revision : 1.0
// ============================================================================
module tb_ysyx_24110017_axi_burst_mem;
    localparam int          DATA_W    = 32;
    localparam int          ID_W      = 4;
    localparam logic [31:0] MEM_BASE  = 32'h8000_0000;
    localparam int          MEM_BYTES = 65536;
    localparam int          RD_LAT    = 3;
    localparam int          WR_LAT    = 3;
    localparam int          TMO       = 100;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_24110017_axi_burst_mem_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    ysyx_24110017_axi_burst_mem #(
        .DATA_W(DATA_W), .ID_W(ID_W), .MEM_BASE(MEM_BASE),
        .MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    rbeat_t      exp_q [$];
    logic [31:0] model_mem [int];
    logic [31:0] wbuf [8];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic bit tb_in_rng(input logic [31:0] a);
        return (a >= MEM_BASE) && ((a - MEM_BASE) < 32'(MEM_BYTES));
    endfunction

    function automatic int tb_idx(input logic [31:0] a);
        return int'((a - MEM_BASE) >> 2);
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [3:0] strb);
        logic [31:0] a, w;
        logic        dec;
        logic [1:0]  er;
        int          t;
        a = addr; dec = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (tb_in_rng(a)) begin
                w = model_mem.exists(tb_idx(a)) ? model_mem[tb_idx(a)] : 32'h0;
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
                model_mem[tb_idx(a)] = w;
            end else begin
                dec = 1'b1;
            end
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
        er = dec ? 2'b11 : ((burst[1] || (nbeats != int'(len) + 1)) ? 2'b10 : 2'b00);

        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        t = 0;
        while (!bus.awready && t < TMO) begin @(negedge clock); t++; end
        check_eq("aw_hs", bus.awready, 1'b1);
        @(negedge clock);
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
            bus.wlast = (i == nbeats - 1);
            t = 0;
            while (!bus.wready && t < TMO) begin @(negedge clock); t++; end
            check_eq("w_hs", bus.wready, 1'b1);
            @(negedge clock);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        t = 0;
        while (!bus.bvalid && t < TMO) begin @(negedge clock); t++; end
        check_eq("b_lat", t, WR_LAT);
        check_eq("bid", bus.bid, id);
        check_eq("bresp", bus.bresp, er);
        bus.bready = 1'b1;
        @(negedge clock);
        bus.bready = 1'b0;
        check_eq("b_drop", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [15:0] pat, input int plen);
        logic [31:0] a, hdata;
        logic        hlast, held;
        rbeat_t      e;
        int          t, pi;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            if (tb_in_rng(a)) begin
                e.data = model_mem.exists(tb_idx(a)) ? model_mem[tb_idx(a)] : 32'h0;
                e.resp = burst[1] ? 2'b10 : 2'b00;
            end else begin
                e.data = 32'h0;
                e.resp = 2'b11;
            end
            exp_q.push_back(e);
            if (burst != 2'b00) a = a + (32'd1 << size);
        end

        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        t = 0;
        while (!bus.arready && t < TMO) begin @(negedge clock); t++; end
        check_eq("ar_hs", bus.arready, 1'b1);
        @(negedge clock);
        bus.arvalid = 1'b0;
        t = 0;
        while (!bus.rvalid && t < TMO) begin @(negedge clock); t++; end
        check_eq("r_lat", t, RD_LAT);

        pi = 0; held = 1'b0; hdata = '0; hlast = 1'b0; t = 0;
        while (exp_q.size() > 0 && t < TMO) begin
            if (bus.rvalid) begin
                if (held) check_eq("r_hold", {bus.rdata, bus.rlast}, {hdata, hlast});
                bus.rready = (pi < plen) ? pat[pi] : 1'b1;
                pi++;
                if (bus.rready) begin
                    e = exp_q.pop_front();
                    check_eq("rdata", bus.rdata, e.data);
                    check_eq("rresp", bus.rresp, e.resp);
                    check_eq("rlast", bus.rlast, e.last);
                    check_eq("rid", bus.rid, e.id);
                    held = 1'b0;
                end else begin
                    held = 1'b1; hdata = bus.rdata; hlast = bus.rlast;
                end
            end
            @(negedge clock);
            t++;
        end
        bus.rready = 1'b0;
        if (exp_q.size() != 0) begin
            check_eq("r_beats_left", exp_q.size(), 0);
            exp_q.delete();
        end
        check_eq("r_end", bus.rvalid, 1'b0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;
        repeat (3) @(negedge clock);
        check_eq("rst_awready", bus.awready, 1'b0);
        check_eq("rst_arready", bus.arready, 1'b0);
        check_eq("rst_bvalid", bus.bvalid, 1'b0);
        check_eq("rst_rvalid", bus.rvalid, 1'b0);
        check_eq("rst_rlast", bus.rlast, 1'b0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Preload four words at the base with an INCR burst
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        axi_write(4'h1, MEM_BASE, 8'd3, 3'd2, 2'b01, 4, 4'hF);

        wbuf[0] = 32'hDEADBEEF;
        axi_write(4'h5, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1, 4'hF);
        axi_read(4'h6, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 16'h0001, 1);

        wbuf[0] = 32'hAABBCCDD;
        axi_write(4'h2, 32'h8000_0014, 8'd0, 3'd2, 2'b01, 1, 4'hF);
        wbuf[0] = 32'h11223344;
        axi_write(4'h3, 32'h8000_0014, 8'd0, 3'd2, 2'b01, 1, 4'b0101);
        axi_read(4'h7, 32'h8000_0014, 8'd0, 3'd2, 2'b01, 16'h0001, 1);

        axi_read(4'h9, MEM_BASE, 8'd3, 3'd2, 2'b01, 16'b101101, 6);

        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
        axi_write(4'hA, 32'h8000_0020, 8'd2, 3'd2, 2'b00, 3, 4'hF);
        axi_read(4'hB, 32'h8000_0020, 8'd0, 3'd2, 2'b01, 16'h0001, 1);

        wbuf[0] = 32'h0BAD_0001; wbuf[1] = 32'h0BAD_0002;
        axi_write(4'hC, 32'h8000_0040, 8'd1, 3'd2, 2'b10, 2, 4'hF);
        axi_write(4'hD, 32'h8000_0050, 8'd2, 3'd2, 2'b01, 2, 4'hF);

        axi_read(4'hE, 32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 16'h0001, 1);
        wbuf[0] = 32'h5555_5555;
        axi_write(4'hF, MEM_BASE + 32'(MEM_BYTES), 8'd0, 3'd2, 2'b01, 1, 4'hF);
        axi_read(4'h4, MEM_BASE, 8'd0, 3'd2, 2'b01, 16'h0001, 1);

        wbuf[0] = 32'h0;
        axi_write(4'h8, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1, 4'h0);
        axi_read(4'h8, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 16'h0001, 1);

        // Reset while beat 2 of a 4-beat read is being presented
        bus.arvalid = 1'b1; bus.arid = 4'h3; bus.araddr = MEM_BASE;
        bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
        t = 0;
        while (!bus.arready && t < TMO) begin @(negedge clock); t++; end
        @(negedge clock);
        bus.arvalid = 1'b0;
        t = 0;
        while (!bus.rvalid && t < TMO) begin @(negedge clock); t++; end
        check_eq("mid_rvalid", bus.rvalid, 1'b1);
        bus.rready = 1'b1;
        @(negedge clock);
        bus.rready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_eq("mid_rst_rvalid", bus.rvalid, 1'b0);
        check_eq("mid_rst_arready", bus.arready, 1'b0);
        reset = 1'b0;
        t = 0;
        while (!bus.arready && t < 4) begin @(negedge clock); t++; end
        check_eq("post_rst_arready", bus.arready, 1'b1);
        axi_read(4'h2, MEM_BASE + 32'd4, 8'd1, 3'd2, 2'b01, 16'h0003, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
